// File: rtl/uart_rx_vote.sv
// Oversampled UART receiver that decides each bit by a 3-sample majority vote and flags framing/parity errors per word.
// Optional parity bit after the data is enabled with the UART_RX_PARITY_EN macro.
module uart_rx_vote #(
  parameter int DBITS      = 8,
  parameter int OVS        = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             ckht,
  input  logic             rst,
  input  logic             rx,
  input  logic             s_tick,
  output logic             rx_done_tick,
  output logic [DBITS-1:0] rx_data,
  output logic             frame_err,
  output logic             parity_err,
  output logic             busy
);

  localparam int SW = $clog2(OVS);
  localparam int NW = $clog2(DBITS);
  localparam logic [SW-1:0] S_MID     = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_END     = SW'(OVS - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBITS - 1);
  localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

  if (DBITS < 5 || DBITS > 9) begin : g_bad_dbits
    $error("uart_rx_vote: DBITS must be 5..9");
  end
  if (OVS < 8 || OVS > 32 || (OVS % 2) != 0) begin : g_bad_ovs
    $error("uart_rx_vote: OVS must be even and 8..32");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_vote: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_rx_vote: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_n;
  logic [SW-1:0]    s, s_n;
  logic [NW-1:0]    n, n_n;
  logic [DBITS-1:0] b, b_n;
  logic             frame_pend, frame_pend_n;
  logic             done_n, ferr_n;
  logic [DBITS-1:0] data_n;
  logic             rx_m, rx_s;
  logic [1:0]       hist;
  logic             vote;
`ifdef UART_RX_PARITY_EN
  logic             par_pend, par_pend_n, perr_n;
`endif

  // Two history samples plus the current one form the vote window.
  assign vote = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n      = state;
    s_n          = s;
    n_n          = n;
    b_n          = b;
    frame_pend_n = frame_pend;
    done_n       = 1'b0;
    data_n       = rx_data;
    ferr_n       = frame_err;
`ifdef UART_RX_PARITY_EN
    par_pend_n   = par_pend;
    perr_n       = parity_err;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n      = START;
          s_n          = '0;
          frame_pend_n = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_pend_n   = 1'b0;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            if (vote) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_END) begin
            b_n = {vote, b[DBITS-1:1]};
            s_n = '0;
            if (n == N_LAST) begin
              n_n = '0;
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s == S_END) begin
            par_pend_n = (^b ^ vote) ^ 1'(PARITY_ODD);
            s_n        = '0;
            state_n    = STOP;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s == S_END) begin
            s_n = '0;
            if (!vote) frame_pend_n = 1'b1;
            // Leave at the decision tick so a low line can retrigger START right away.
            if (n == STOP_LAST) begin
              state_n = IDLE;
              n_n     = '0;
              done_n  = 1'b1;
              data_n  = b;
              ferr_n  = frame_pend | ~vote;
`ifdef UART_RX_PARITY_EN
              perr_n  = par_pend;
`endif
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge ckht) begin
    if (rst) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      frame_pend   <= 1'b0;
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
      hist         <= 2'b11;
      rx_done_tick <= 1'b0;
      rx_data      <= '0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend     <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      s            <= s_n;
      n            <= n_n;
      b            <= b_n;
      frame_pend   <= frame_pend_n;
      rx_m         <= rx;
      rx_s         <= rx_m;
      if (s_tick) hist <= {hist[0], rx_s};
      rx_done_tick <= done_n;
      rx_data      <= data_n;
      frame_err    <= ferr_n;
      busy         <= (state_n != IDLE);
`ifdef UART_RX_PARITY_EN
      par_pend     <= par_pend_n;
      parity_err   <= perr_n;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_vote.md
# uart_rx_vote

Parametrised UART receiver, successor to the fixed 8N1 receiver in the serial front end. It accepts the raw `rx` line and the oversampling `s_tick` from the shared baud-rate generator, and supports configurable data width, stop-bit count and oversampling ratio. Each bit is decided by 3-sample majority vote, and false start bits are rejected. It reports framing and optional parity errors alongside each received word for the downstream FIFO.

## Interface
- `DBITS`, 8: data bits per word, legal 5..9.
- `OVS`, 16: `s_tick`s per bit period, even, legal 8..32.
- `STOP_BITS`, 1: stop bits checked, legal 1 or 2.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Used only with `UART_RX_PARITY_EN`.
- Illegal parameter values: elaboration `$error`.

Ports:
- `ckht` in 1: system clock. Single clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `rx` in 1: asynchronous serial line, idle high.
- `s_tick` in 1: one-`ckht` oversampling strobe.
- `rx_done_tick` out 1: one-cycle pulse, word complete.
- `rx_data` out `DBITS`: received word, LSB first on the line.
- `frame_err` out 1: a stop bit was voted 0.
- `parity_err` out 1: parity mismatch.
- `busy` out 1: receiver not in IDLE.

## Operation
- Input synchronizer: 2 flops, reset to 1, producing `rx_s`. Adds 2 `ckht` of latency.
- Vote: keep the last 3 `rx_s` values sampled on `s_tick`. The bit value is the majority of the 3, taken on the decision tick (that tick's sample included).
- Counters:
  - `s`: `$clog2(OVS)` bits, counts `s_tick`s.
  - `n`: `$clog2(DBITS)` bits, counts data bits.
- IDLE:
  - `rx_s == 0` → START, `s = 0`.
- START:
  - Decision tick is `s == OVS/2-1`.
  - Vote 1 → IDLE (false start, no output).
  - Vote 0 → DATA, `s = 0`, `n = 0`.
- DATA:
  - Decision tick is `s == OVS-1`. Then `b = {vote, b[DBITS-1:1]}` and `s = 0`.
  - When `n == DBITS-1`: go to PARITY if enabled, else STOP. Otherwise `n++`.
- PARITY:
  - Decision tick is `s == OVS-1`.
  - Error is `(^b ^ vote) ^ PARITY_ODD`, latched into a pending flag.
- STOP:
  - `STOP_BITS` periods, each decided at `s == OVS-1`.
  - Any 0 vote sets pending framing error.
  - After the last stop decision → IDLE immediately (no wait for the bit end), so a low line retriggers START.
- Ticks:
  - `s` advances only on `s_tick`.
  - `s_tick` in IDLE is ignored.
- `busy = (state != IDLE)`, registered with the state.

## Timing
- Reset values:
  - State IDLE, `s = 0`, `n = 0`, `b = 0`, sync flops = 1.
  - `rx_done_tick = 0`, `rx_data = 0`, `frame_err = 0`, `parity_err = 0`, `busy = 0`.
- Reset asserted mid-frame: everything returns to reset values on the next edge and the partial word is discarded.
- Final stop decision in cycle T. In cycle T+1:
  - `rx_done_tick = 1` for exactly one cycle.
  - `rx_data`, `frame_err` and `parity_err` are updated and become valid.
- Those three outputs hold until the next `rx_done_tick`. Error flags are therefore per-word: a good frame clears them.
- Errors do not suppress `rx_done_tick`. A corrupted word is still delivered, with its flag set.
- Line to done latency: 2 `ckht` (sync) + bit timing + 1 `ckht`.
- No handshake back-pressure. The consumer must accept on `rx_done_tick`.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state exists, one parity bit is expected after the data.
  - `parity_err` reports mismatch per `PARITY_ODD`.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; DATA goes directly to STOP.
  - `parity_err` is tied to 0 and `PARITY_ODD` is ignored.

## Test plan
- Clean frame (OVS=16, DBITS=8, `s_tick` every 4 `ckht`), 0x55 8N1 → exactly one `rx_done_tick`, `rx_data = 0x55`, `frame_err = 0`, `parity_err = 0`, `busy` falls in the same cycle.
- False start: rx low for 3 ticks, then high → no `rx_done_tick`, `busy` returns to 0 after the START decision, `rx_data` unchanged.
- Majority vote: frame 0xA5, with one of the 3 vote samples inverted in every data bit → `rx_data = 0xA5`, no errors.
- Framing error: 0x3C with the stop bit low → done pulse, `rx_data = 0x3C`, `frame_err = 1`. Next clean frame 0x0F → `frame_err = 0`.
- Parity (`UART_RX_PARITY_EN`, `PARITY_ODD = 0`): 0x07 with parity bit 0 → `parity_err = 1`. Same word with parity bit 1 → `parity_err = 0`.
- Reset mid-frame: assert `rst` during data bit 4 → next cycle `busy = 0` and all outputs 0. Following frame 0x81 → `rx_data = 0x81`.
